// File: rtl/light_level_ctrl.sv
// Parametrised light-level controller: edge-detected off/up/down buttons,
// auto-repeat on held up/down, saturate or wrap at the ends, optional idle timeout.
module light_level_ctrl #(
  parameter int NUM_LEVELS    = 5,
  parameter int LEVEL_W       = 3,
  parameter int WRAP          = 0,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [2:0]         i_button,
  output logic [LEVEL_W-1:0] o_lightState,
  output logic               o_change,
  output logic               o_atMin,
  output logic               o_atMax
);

  // state     | meaning
  // ST_IDLE   | no direction latched, waiting for an up/down press
  // ST_HOLD   | latched button held, counting towards first repeat
  // ST_REPEAT | latched button still held, stepping every REPEAT_CYCLES
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam int CNT_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES - 1 : REPEAT_CYCLES - 1;
  localparam int CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int IDLE_MAX = (IDLE_TIMEOUT > 1) ? IDLE_TIMEOUT - 1 : 1;
  localparam int IDLE_W   = (IDLE_MAX < 2) ? 1 : $clog2(IDLE_MAX + 1);

  localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0]   HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_TC   = IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  logic [2:0]         btn_prev;
  logic [1:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDLE_W-1:0]  idle_cnt, idle_nxt;
  logic               dir_up, dir_up_nxt;
  logic [2:0]         press;
  logic               held;
  logic [LEVEL_W-1:0] lvl_nxt;

  function automatic logic [LEVEL_W-1:0] step_lvl(input logic [LEVEL_W-1:0] lvl,
                                                  input logic up);
    if (up) begin
      if (lvl == MAX_LVL) return (WRAP != 0) ? '0 : MAX_LVL;
      return lvl + LEVEL_W'(1);
    end
    if (lvl == '0) return (WRAP != 0) ? MAX_LVL : '0;
    return lvl - LEVEL_W'(1);
  endfunction

  assign press = i_button & ~btn_prev;
  assign held  = dir_up ? i_button[1] : i_button[2];

  always_comb begin
    lvl_nxt    = o_lightState;
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_up_nxt = dir_up;
    idle_nxt   = idle_cnt;

    if (press[0]) begin
      lvl_nxt   = '0;
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (press[1] || press[2]) begin
      // up wins over down; a press of the other direction re-latches and restarts the hold
      dir_up_nxt = press[1];
      lvl_nxt    = step_lvl(o_lightState, press[1]);
      state_nxt  = ST_HOLD;
      cnt_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: cnt_nxt = '0;
        ST_HOLD, ST_REPEAT: begin
          if (!held) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == ((state == ST_HOLD) ? HOLD_TC : REPEAT_TC)) begin
            lvl_nxt   = step_lvl(o_lightState, dir_up);
            state_nxt = ST_REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Timeout only fires on a fully quiet cycle, so any button activity wins over it
    if (IDLE_TIMEOUT > 0) begin
      if ((|i_button) || (lvl_nxt != o_lightState)) begin
        idle_nxt = '0;
      end else if (o_lightState != '0) begin
        if (idle_cnt == IDLE_TC) begin
          lvl_nxt  = '0;
          idle_nxt = '0;
        end else begin
          idle_nxt = idle_cnt + IDLE_W'(1);
        end
      end
    end else begin
      idle_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_lightState <= '0;
      o_change     <= 1'b0;
      o_atMin      <= 1'b1;
      o_atMax      <= 1'b0;
      btn_prev     <= 3'b111;
      state        <= ST_IDLE;
      cnt          <= '0;
      dir_up       <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      o_lightState <= lvl_nxt;
      o_change     <= (lvl_nxt != o_lightState);
      o_atMin      <= (lvl_nxt == '0);
      o_atMax      <= (lvl_nxt == MAX_LVL);
      btn_prev     <= i_button;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      dir_up       <= dir_up_nxt;
      idle_cnt     <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_light_level_ctrl.sv
// Scoreboard bench: two controller configurations share stimulus; a reference model
// queues expected level changes and a monitor checks them against o_change pulses.
module tb_light_level_ctrl;

  localparam int A_N = 5, A_W = 0, A_H = 16, A_R = 4, A_T = 0;
  localparam int B_N = 5, B_W = 1, B_H = 3,  B_R = 2, B_T = 100;
  localparam int PN[2] = '{A_N, B_N};
  localparam int PW[2] = '{A_W, B_W};
  localparam int PH[2] = '{A_H, B_H};
  localparam int PR[2] = '{A_R, B_R};
  localparam int PT[2] = '{A_T, B_T};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [2:0] lvl_o [2];
  logic       chg_o [2];
  logic       min_o [2];
  logic       max_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  int         exp_q [2][$];
  int         m_lvl [2];
  int         m_dir [2];
  int         m_age [2];
  int         m_quiet [2];
  logic [2:0] m_prev [2];

  always #5 clk = ~clk;

  light_level_ctrl #(.NUM_LEVELS(A_N), .LEVEL_W(3), .WRAP(A_W), .HOLD_CYCLES(A_H),
                     .REPEAT_CYCLES(A_R), .IDLE_TIMEOUT(A_T)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_button(btn), .o_lightState(lvl_o[0]),
    .o_change(chg_o[0]), .o_atMin(min_o[0]), .o_atMax(max_o[0]));

  light_level_ctrl #(.NUM_LEVELS(B_N), .LEVEL_W(3), .WRAP(B_W), .HOLD_CYCLES(B_H),
                     .REPEAT_CYCLES(B_R), .IDLE_TIMEOUT(B_T)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_button(btn), .o_lightState(lvl_o[1]),
    .o_change(chg_o[1]), .o_atMin(min_o[1]), .o_atMax(max_o[1]));

  task automatic chk(input string name, input int i, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, i, $time, got, exp);
    end
  endtask

  function automatic int move(input int i, input int lvl, input int d);
    int n;
    n = lvl + d;
    if (n < 0)      n = (PW[i] != 0) ? PN[i] - 1 : 0;
    if (n >= PN[i]) n = (PW[i] != 0) ? 0 : PN[i] - 1;
    return n;
  endfunction

  // Reference: steps happen on the press edge, then at H edges after it, then every R edges
  task automatic model_step(input int i, input logic [2:0] b);
    logic [2:0] pr;
    int lvl, nl;
    lvl = m_lvl[i];
    nl  = lvl;
    pr  = b & ~m_prev[i];
    if (pr[0]) begin
      nl = 0;
      m_dir[i] = 0;
    end else if (pr[1]) begin
      nl = move(i, lvl, 1);
      m_dir[i] = 1;
      m_age[i] = 0;
    end else if (pr[2]) begin
      nl = move(i, lvl, -1);
      m_dir[i] = -1;
      m_age[i] = 0;
    end else if (m_dir[i] != 0) begin
      if (!((m_dir[i] == 1) ? b[1] : b[2])) begin
        m_dir[i] = 0;
      end else begin
        m_age[i]++;
        if (m_age[i] >= PH[i] && ((m_age[i] - PH[i]) % PR[i]) == 0)
          nl = move(i, lvl, m_dir[i]);
      end
    end
    if (PT[i] > 0) begin
      if (b != 3'b000 || nl != lvl) begin
        m_quiet[i] = 0;
      end else if (lvl != 0) begin
        m_quiet[i]++;
        if (m_quiet[i] == PT[i]) begin
          nl = 0;
          m_quiet[i] = 0;
        end
      end
    end
    m_prev[i] = b;
    if (nl != lvl) exp_q[i].push_back(nl);
    m_lvl[i] = nl;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i]   = 0;
      m_dir[i]   = 0;
      m_age[i]   = 0;
      m_quiet[i] = 0;
      m_prev[i]  = 3'b111;
      exp_q[i].delete();
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_level",  i, int'(lvl_o[i]), 0);
      chk("rst_atMin",  i, int'(min_o[i]), 1);
      chk("rst_atMax",  i, int'(max_o[i]), 0);
      chk("rst_change", i, int'(chg_o[i]), 0);
    end
  endtask

  task automatic cyc(input logic [2:0] b);
    btn = b;
    @(posedge clk);
    if (!rst) begin
      model_step(0, b);
      model_step(1, b);
    end
    #1;
  endtask

  task automatic pulse(input logic [2:0] b);
    cyc(b);
    cyc(3'b000);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        int ref_lvl;
        ref_lvl = m_lvl[i];
        if (chg_o[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_change", i, 1, 0);
          end else begin
            ref_lvl = exp_q[i].pop_front();
            chk("change_level", i, int'(lvl_o[i]), ref_lvl);
          end
        end else begin
          if (exp_q[i].size() != 0) begin
            chk("missed_change", i, 0, 1);
            exp_q[i].delete();
          end
          chk("steady_level", i, int'(lvl_o[i]), ref_lvl);
        end
        chk("atMin", i, int'(min_o[i]), (ref_lvl == 0) ? 1 : 0);
        chk("atMax", i, int'(max_o[i]), (ref_lvl == PN[i] - 1) ? 1 : 0);
      end
    end
  end

  initial begin
    logic [2:0] b;
    reset_model();
    repeat (2) @(posedge clk);
    #2;
    check_reset();
    rst = 1'b0;

    // basic stepping, saturation vs wrap at the top, then off
    repeat (5) pulse(3'b010);
    pulse(3'b001);
    // bottom end: down at 0 saturates or wraps, then up from max
    pulse(3'b100);
    pulse(3'b010);
    pulse(3'b001);

    // hold up for 30 cycles, then release
    repeat (30) cyc(3'b010);
    repeat (6) cyc(3'b000);
    pulse(3'b001);

    // simultaneous up+down, then off while held in repeat
    pulse(3'b110);
    pulse(3'b001);
    repeat (22) cyc(3'b010);
    cyc(3'b011);
    repeat (10) cyc(3'b010);
    cyc(3'b000);
    pulse(3'b010);
    pulse(3'b001);

    // idle timeout, then a button pulse just before expiry restarting the count
    repeat (3) pulse(3'b010);
    repeat (110) cyc(3'b000);
    repeat (3) pulse(3'b010);
    repeat (97) cyc(3'b000);
    cyc(3'b100);
    repeat (99) cyc(3'b000);
    repeat (4) cyc(3'b000);
    pulse(3'b001);

    // randomized button traffic with occasional long quiet stretches
    b = 3'b000;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        b[0] = ($urandom_range(0, 19) == 0);
        b[1] = 1'($urandom_range(0, 1));
        b[2] = ($urandom_range(0, 2) == 0);
      end
      cyc(b);
      if ($urandom_range(0, 299) == 0) repeat (105) cyc(3'b000);
    end

    // asynchronous reset mid-repeat with up held through deassertion
    pulse(3'b001);
    repeat (22) cyc(3'b010);
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    reset_model();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (20) cyc(3'b010);
    cyc(3'b000);
    pulse(3'b010);
    repeat (3) cyc(3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
